// File: rtl/vga_pkg.sv
// Shared constants, direction types and colour packing helpers for the VGA box engine.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int RGB_CH       = 3;

  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_x_t;
  typedef enum logic {DIR_DOWN  = 1'b0, DIR_UP   = 1'b1} dir_y_t;
  // Axis-neutral form used by the motion engine: FWD is RIGHT or DOWN.
  typedef enum logic {DIR_FWD   = 1'b0, DIR_BACK = 1'b1} axis_dir_t;

  function automatic int rgb_w(input int color_w);
    return RGB_CH * color_w;
  endfunction

endpackage

// File: rtl/vga_box_motion.sv
// Single-axis bounce engine: steps the box edge once per enabled tick and reflects
// off both walls, emitting a combinational reflect flag in the tick cycle.
module vga_box_motion
  import vga_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int EXTENT = 640,
  parameter int SIZE   = 64,
  parameter int STEP   = 4,
  parameter int POS0   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  output logic [ADDR_W-1:0] o_pos,
  output logic              o_reflect
);

  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(EXTENT - SIZE);
  localparam logic [ADDR_W:0] STEP_W = (ADDR_W+1)'(STEP);

  axis_dir_t         r_dir, w_dir_next;
  logic [ADDR_W-1:0] r_pos, w_pos_next;
  logic [ADDR_W:0]   w_pos_ext;
  logic              w_wall;

  assign w_pos_ext = {1'b0, r_pos};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir <= DIR_FWD;
      r_pos <= ADDR_W'(POS0);
    end else begin
      r_dir <= w_dir_next;
      r_pos <= w_pos_next;
    end
  end

  // Limits are compared one bit wider so pos+STEP cannot wrap past the wall.
  always_comb begin
    w_dir_next = r_dir;
    w_pos_next = r_pos;
    w_wall     = 1'b0;
    if (i_tick) begin
      if (r_dir == DIR_FWD) begin
        if (w_pos_ext + STEP_W >= LIMIT) begin
          w_pos_next = LIMIT[ADDR_W-1:0];
          w_dir_next = DIR_BACK;
          w_wall     = 1'b1;
        end else begin
          w_pos_next = r_pos + STEP_W[ADDR_W-1:0];
        end
      end else begin
        if (w_pos_ext <= STEP_W) begin
          w_pos_next = '0;
          w_dir_next = DIR_FWD;
          w_wall     = 1'b1;
        end else begin
          w_pos_next = r_pos - STEP_W[ADDR_W-1:0];
        end
      end
    end
  end

  always_comb begin
    o_pos     = r_pos;
    o_reflect = w_wall;
  end

endmodule

// File: rtl/vga_box_engine.sv
// Single bouncing/static rectangle over a background, 1-cycle registered RGB output.
// Optional one-pixel screen border in box colour when VGA_BORDER_EN is defined.
module vga_box_engine
  import vga_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int COLOR_W  = 1,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_W    = 64,
  parameter int BOX_H    = 48,
  parameter int STEP     = 4,
  parameter int X0       = 0,
  parameter int Y0       = 0
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        Ready_Sig,
  input  logic [ADDR_W-1:0]           Column_Addr_Sig,
  input  logic [ADDR_W-1:0]           Row_Addr_Sig,
  input  logic                        Mode_Sig,
  input  logic [rgb_w(COLOR_W)-1:0]   Fg_Rgb,
  input  logic [rgb_w(COLOR_W)-1:0]   Bg_Rgb,
  output logic [COLOR_W-1:0]          Red_Sig,
  output logic [COLOR_W-1:0]          Green_Sig,
  output logic [COLOR_W-1:0]          Blue_Sig,
  output logic                        Bounce_Sig
);

  localparam int RGB_W = rgb_w(COLOR_W);

  logic              r_mode;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_bounce;

  logic              w_tick, w_move, w_hit, w_border;
  logic              w_reflect_x, w_reflect_y;
  logic [ADDR_W-1:0] w_box_x, w_box_y;
  logic [ADDR_W:0]   w_col, w_row, w_x_lo, w_y_lo;
  logic [RGB_W-1:0]  w_rgb_next;

  assign w_tick = Ready_Sig
               && (Column_Addr_Sig == ADDR_W'(H_ACTIVE - 1))
               && (Row_Addr_Sig    == ADDR_W'(V_ACTIVE - 1));
  // Motion uses the mode held before this tick; the new mode applies from the next frame.
  assign w_move = w_tick && r_mode;

  vga_box_motion #(
    .ADDR_W(ADDR_W), .EXTENT(H_ACTIVE), .SIZE(BOX_W), .STEP(STEP), .POS0(X0)
  ) u_motion_x (
    .i_clk(CLK), .i_rst_n(RSTn), .i_tick(w_move), .o_pos(w_box_x), .o_reflect(w_reflect_x)
  );

  vga_box_motion #(
    .ADDR_W(ADDR_W), .EXTENT(V_ACTIVE), .SIZE(BOX_H), .STEP(STEP), .POS0(Y0)
  ) u_motion_y (
    .i_clk(CLK), .i_rst_n(RSTn), .i_tick(w_move), .o_pos(w_box_y), .o_reflect(w_reflect_y)
  );

  assign w_col  = {1'b0, Column_Addr_Sig};
  assign w_row  = {1'b0, Row_Addr_Sig};
  assign w_x_lo = {1'b0, w_box_x};
  assign w_y_lo = {1'b0, w_box_y};
  assign w_hit  = Ready_Sig
               && (w_col >= w_x_lo) && (w_col < w_x_lo + (ADDR_W+1)'(BOX_W))
               && (w_row >= w_y_lo) && (w_row < w_y_lo + (ADDR_W+1)'(BOX_H));

`ifdef VGA_BORDER_EN
  assign w_border = Ready_Sig
                 && ((Column_Addr_Sig == '0) || (Column_Addr_Sig == ADDR_W'(H_ACTIVE - 1))
                  || (Row_Addr_Sig == '0)    || (Row_Addr_Sig    == ADDR_W'(V_ACTIVE - 1)));
`else
  assign w_border = 1'b0;
`endif

  always_comb begin
    w_rgb_next = '0;
    if (Ready_Sig) w_rgb_next = (w_hit || w_border) ? Fg_Rgb : Bg_Rgb;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_mode   <= 1'b0;
      r_rgb    <= '0;
      r_bounce <= 1'b0;
    end else begin
      if (w_tick) r_mode <= Mode_Sig;
      r_rgb    <= w_rgb_next;
      r_bounce <= w_reflect_x | w_reflect_y;
    end
  end

  assign Red_Sig    = r_rgb[RGB_W-1 -: COLOR_W];
  assign Green_Sig  = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign Blue_Sig   = r_rgb[COLOR_W-1:0];
  assign Bounce_Sig = r_bounce;

endmodule

// File: tb/tb_vga_box_engine.sv
// Scoreboard bench for vga_box_engine: driver queues expected {R,G,B,Bounce} per vector,
// monitor compares one cycle later. Frame ticks are driven directly as pixel (639,479).
module tb_vga_box_engine;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Ready_Sig = 1'b0;
  logic [10:0] Column_Addr_Sig = '0;
  logic [10:0] Row_Addr_Sig = '0;
  logic        Mode_Sig = 1'b0;
  logic [2:0]  Fg_Rgb = 3'b111;
  logic [2:0]  Bg_Rgb = 3'b000;
  logic        Red_Sig, Green_Sig, Blue_Sig, Bounce_Sig;

`ifdef VGA_BORDER_EN
  localparam logic [2:0] EDGE_RGB = 3'b111;
`else
  localparam logic [2:0] EDGE_RGB = 3'b000;
`endif

  vga_box_engine dut (
    .CLK(CLK), .RSTn(RSTn), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .Mode_Sig(Mode_Sig), .Fg_Rgb(Fg_Rgb), .Bg_Rgb(Bg_Rgb),
    .Red_Sig(Red_Sig), .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig), .Bounce_Sig(Bounce_Sig)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] q_exp[$];
  int         q_due[$];
  string      q_name[$];

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("[check] %s rgb+bounce=%b ok", nm, act);
    end else begin
      $display("FAIL %s: got rgb+bounce=%b, expected %b", nm, act, exp);
    end
  endtask

  // Monitor: outputs visible after edge 'due' reflect the vector queued one cycle earlier.
  initial begin
    forever begin
      @(posedge CLK); #2;
      while (q_due.size() > 0 && q_due[0] <= cyc) begin
        check(q_name[0], {Red_Sig, Green_Sig, Blue_Sig, Bounce_Sig}, q_exp[0]);
        void'(q_exp.pop_front());
        void'(q_due.pop_front());
        void'(q_name.pop_front());
      end
    end
  end

  task automatic drive(input logic rdy, input int c, input int r,
                       input logic [2:0] e_rgb, input logic e_b, input string nm);
    @(posedge CLK); #1;
    Ready_Sig       = rdy;
    Column_Addr_Sig = 11'(c);
    Row_Addr_Sig    = 11'(r);
    q_exp.push_back({e_rgb, e_b});
    q_due.push_back(cyc + 1);
    q_name.push_back(nm);
  endtask

  task automatic px(input int c, input int r, input logic [2:0] e_rgb);
    drive(1'b1, c, r, e_rgb, 1'b0, $sformatf("pix(%0d,%0d)", c, r));
  endtask

  task automatic tick(input logic e_b, input string nm);
    drive(1'b1, 639, 479, EDGE_RGB, e_b, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q_due.size() != 0; i++) @(negedge CLK);
    if (q_due.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected outputs never compared, required 0", q_due.size());
      q_exp.delete(); q_due.delete(); q_name.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_outputs", {Red_Sig, Green_Sig, Blue_Sig, Bounce_Sig}, 4'b0000);
    @(negedge CLK); RSTn = 1'b1;

    // Static box at (0,0)
    px(0, 0, 3'b111);
    px(63, 47, 3'b111);
    px(64, 5, 3'b000);
    px(5, 48, 3'b000);
    drive(1'b0, 10, 10, 3'b000, 1'b0, "ready_low");
    Bg_Rgb = 3'b010;
    px(100, 100, 3'b010);
    drive(1'b0, 100, 100, 3'b000, 1'b0, "ready_low_bg");
    Bg_Rgb = 3'b000;
    px(700, 10, 3'b000);
    px(100, 500, 3'b000);
    px(639, 200, EDGE_RGB);

    // Mode toggled without a tick must not arm motion; first tick arms, second moves.
    Mode_Sig = 1'b1;
    px(30, 30, 3'b111);
    tick(1'b0, "arm_tick");
    px(0, 0, 3'b111);
    tick(1'b0, "tick1");
    px(3, 3, 3'b000);
    px(4, 4, 3'b111);
    px(67, 51, 3'b111);
    px(68, 4, 3'b000);

    for (int n = 2; n <= 108; n++) tick(n == 108, $sformatf("tick%0d", n));
    px(432, 432, 3'b111);
    px(432, 431, 3'b000);
    tick(1'b0, "tick109");
    px(436, 428, 3'b111);
    px(436, 427, 3'b000);
    px(435, 428, 3'b000);

    for (int n = 110; n <= 288; n++)
      tick(n == 144 || n == 216 || n == 288, $sformatf("tick%0d", n));
    px(0, 288, 3'b111);
    px(1, 287, 3'b000);
    tick(1'b0, "tick289");
    px(4, 292, 3'b111);
    px(3, 292, 3'b000);

    // Mid-frame mode drop: this frame's tick still moves, later ticks hold.
    px(50, 50, 3'b000);
    Mode_Sig = 1'b0;
    px(4, 292, 3'b111);
    tick(1'b0, "tick_mode_drop");
    px(8, 296, 3'b111);
    tick(1'b0, "hold1");
    tick(1'b0, "hold2");
    px(8, 296, 3'b111);
    px(7, 296, 3'b000);
    px(8, 295, 3'b000);
    Mode_Sig = 1'b1;
    tick(1'b0, "rearm");
    px(8, 296, 3'b111);
    tick(1'b0, "resume");
    px(12, 300, 3'b111);
    px(11, 300, 3'b000);

    for (int k = 1; k <= 47; k++) tick(k == 33, $sformatf("run_tick%0d", k));
    px(199, 376, 3'b000);
    px(200, 376, 3'b111);
    drain();

    // Asynchronous reset mid-frame with the box at (200,376)
    RSTn = 1'b0;
    #1;
    check("async_reset_now", {Red_Sig, Green_Sig, Blue_Sig, Bounce_Sig}, 4'b0000);
    @(posedge CLK); #1;
    Column_Addr_Sig = '0; Row_Addr_Sig = '0;
    @(posedge CLK); #1;
    check("reset_held", {Red_Sig, Green_Sig, Blue_Sig, Bounce_Sig}, 4'b0000);
    @(negedge CLK); RSTn = 1'b1;

    px(0, 0, 3'b111);
    px(63, 47, 3'b111);
    px(200, 376, 3'b000);
    px(639, 200, EDGE_RGB);
    tick(1'b0, "post_reset_arm");
    px(3, 3, 3'b111);
    tick(1'b0, "post_reset_move");
    px(3, 3, 3'b000);
    px(4, 4, 3'b111);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
